reg_bank_mp: RTL and testbench



---
 rtl/reg_bank_mp.sv | 115 +++++++++++
 tb/tb_reg_bank_mp.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - multi-port register bank with write-first bypass and bulk-clear sequencer
module reg_bank_mp #(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
    output logic [DATA_W-1:0]        rd_data_a,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
    output logic [DATA_W-1:0]        rd_data_b,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic              clearing;
    logic              wr_fire;

    assign clearing  = (state_q == ST_CLEAR);
    assign wr_fire   = wr_en & ~clearing;
    assign wr_ready  = ~clearing;
    assign clr_busy  = clearing;
    assign clr_done  = done_q;
    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A write and a clear never coincide: writes are blocked while clearing.
    always_comb begin
        mem_d = mem_q;
        if (wr_fire) begin
            mem_d[wr_addr] = wr_data;
        end
        if (clearing) begin
            mem_d[ptr_q] = '0;
        end
    end

    always_comb begin
        rd_a_d = mem_q[rd_addr_a];
        if (wr_fire && (wr_addr == rd_addr_a)) begin
            rd_a_d = wr_data;
        end
        if (clearing && (ptr_q == rd_addr_a)) begin
            rd_a_d = '0;
        end
        rd_b_d = mem_q[rd_addr_b];
        if (wr_fire && (wr_addr == rd_addr_b)) begin
            rd_b_d = wr_data;
        end
        if (clearing && (ptr_q == rd_addr_b)) begin
            rd_b_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_reg_bank_mp.sv
// tb/tb_reg_bank_mp.sv - bench for reg_bank_mp (16x8 and 32x16 instances)
module tb_reg_bank_mp;
    logic clk;
    int checks = 0;
    int errors = 0;

    logic        reset0, wr_en0, clr_req0;
    logic [2:0]  wr_addr0, rd_addr_a0, rd_addr_b0;
    logic [15:0] wr_data0, rd_data_a0, rd_data_b0;
    logic        wr_ready0, clr_busy0, clr_done0;

    logic        reset1, wr_en1, clr_req1;
    logic [3:0]  wr_addr1, rd_addr_a1, rd_addr_b1;
    logic [31:0] wr_data1, rd_data_a1, rd_data_b1;
    logic        wr_ready1, clr_busy1, clr_done1;

    reg_bank_mp #(.DATA_W(16), .DEPTH(8), .RESET_VAL(16'hA5A5)) dut0 (
        .clk(clk), .reset(reset0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .wr_ready(wr_ready0), .rd_addr_a(rd_addr_a0), .rd_data_a(rd_data_a0),
        .rd_addr_b(rd_addr_b0), .rd_data_b(rd_data_b0), .clr_req(clr_req0),
        .clr_busy(clr_busy0), .clr_done(clr_done0)
    );

    reg_bank_mp #(.DATA_W(32), .DEPTH(16), .RESET_VAL(32'hDEADBEEF)) dut1 (
        .clk(clk), .reset(reset1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .wr_ready(wr_ready1), .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1),
        .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1), .clr_req(clr_req1),
        .clr_busy(clr_busy1), .clr_done(clr_done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Model of dut0: registers as a plain array, the clear as "index being cleared" (-1 = none).
    logic [15:0] m [8];
    logic [15:0] ea = '0, eb = '0;
    int          cidx = -1;
    logic        edone = 1'b0;
    bit          mvalid = 1'b0;

    always @(posedge clk) begin : model
        logic [15:0] nm [8];
        if (reset0) begin
            for (int i = 0; i < 8; i++) m[i] = 16'hA5A5;
            ea = '0; eb = '0; cidx = -1; edone = 1'b0; mvalid = 1'b1;
        end else begin
            nm = m;
            if (wr_en0 && cidx < 0) nm[wr_addr0] = wr_data0;
            if (cidx >= 0) nm[cidx] = 16'h0000;
            // A read returns what the register holds once this edge has been applied.
            ea = nm[rd_addr_a0];
            eb = nm[rd_addr_b0];
            edone = (cidx == 7);
            if (cidx >= 0) cidx = (cidx == 7) ? -1 : cidx + 1;
            else if (clr_req0) cidx = 0;
            m = nm;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_rd_a", 32'(rd_data_a0), 32'(ea));
            chk("model_rd_b", 32'(rd_data_b0), 32'(eb));
            chk("model_busy", 32'(clr_busy0), 32'(cidx >= 0));
            chk("model_ready", 32'(wr_ready0), 32'(cidx < 0));
            chk("model_done", 32'(clr_done0), 32'(edone));
        end
    end

    task automatic wait_done0(input string name);
        int n = 0;
        while (!clr_done0 && n < 40) begin
            cyc();
            n++;
        end
        chk(name, 32'(clr_done0), 32'd1);
    endtask

    initial begin
        int n;
        reset0 = 1; wr_en0 = 0; clr_req0 = 0; wr_addr0 = 0; wr_data0 = 0; rd_addr_a0 = 0; rd_addr_b0 = 0;
        reset1 = 1; wr_en1 = 0; clr_req1 = 0; wr_addr1 = 0; wr_data1 = 0; rd_addr_a1 = 0; rd_addr_b1 = 0;
        cyc(); cyc();
        reset0 = 0; reset1 = 0;
        chk("rst_ready", 32'(wr_ready0), 32'd1);
        chk("rst_busy", 32'(clr_busy0), 32'd0);
        chk("rst_done", 32'(clr_done0), 32'd0);
        chk("rst_rd_a_zero", 32'(rd_data_a0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a0 = 3'(i); rd_addr_b0 = 3'(7 - i);
            cyc();
            chk("rst_val_a", 32'(rd_data_a0), 32'h0000A5A5);
            chk("rst_val_b", 32'(rd_data_b0), 32'h0000A5A5);
        end

        // write r3 with both ports reading r3 in the same cycle
        wr_en0 = 1; wr_addr0 = 3; wr_data0 = 16'h1234; rd_addr_a0 = 3; rd_addr_b0 = 3;
        cyc();
        wr_en0 = 0;
        chk("bypass_a", 32'(rd_data_a0), 32'h1234);
        chk("bypass_b", 32'(rd_data_b0), 32'h1234);
        rd_addr_a0 = 5;
        cyc();
        chk("r5_unchanged", 32'(rd_data_a0), 32'hA5A5);
        chk("r3_stored", 32'(rd_data_b0), 32'h1234);

        // fill, then clear with a dropped write to r2 mid-clear
        for (int i = 0; i < 8; i++) begin
            wr_en0 = 1; wr_addr0 = 3'(i); wr_data0 = 16'(16'h11 * (i + 1));
            cyc();
        end
        wr_en0 = 0;
        rd_addr_a0 = 7;
        cyc();
        chk("fill_r7", 32'(rd_data_a0), 32'h88);
        clr_req0 = 1;
        cyc();
        clr_req0 = 0;
        for (int k = 0; k < 8; k++) begin
            chk("clr_busy_win", 32'(clr_busy0), 32'd1);
            chk("clr_ready_low", 32'(wr_ready0), 32'd0);
            if (k == 2) begin
                wr_en0 = 1; wr_addr0 = 2; wr_data0 = 16'hBEEF;
            end else begin
                wr_en0 = 0;
            end
            cyc();
        end
        wr_en0 = 0;
        chk("clr_done_pulse", 32'(clr_done0), 32'd1);
        chk("clr_done_busy", 32'(clr_busy0), 32'd0);
        chk("clr_done_ready", 32'(wr_ready0), 32'd1);
        cyc();
        chk("clr_done_once", 32'(clr_done0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a0 = 3'(i);
            cyc();
            chk("cleared_val", 32'(rd_data_a0), 32'd0);
        end

        // write and clear request together in IDLE
        wr_en0 = 1; wr_addr0 = 1; wr_data0 = 16'h4242; clr_req0 = 1; rd_addr_a0 = 1; rd_addr_b0 = 1;
        cyc();
        wr_en0 = 0; clr_req0 = 0;
        chk("wr_with_req", 32'(rd_data_a0), 32'h4242);
        wait_done0("wr_req_done");
        cyc();
        chk("wr_req_cleared", 32'(rd_data_a0), 32'd0);

        // clear bypass: read r4 while ptr==4, r6 not yet cleared
        wr_en0 = 1; wr_addr0 = 4; wr_data0 = 16'h7777;
        cyc();
        wr_addr0 = 6;
        cyc();
        wr_en0 = 0;
        clr_req0 = 1;
        cyc();
        clr_req0 = 0;
        cyc(); cyc(); cyc(); cyc();
        rd_addr_a0 = 4; rd_addr_b0 = 6;
        cyc();
        chk("clr_bypass_r4", 32'(rd_data_a0), 32'd0);
        chk("clr_pending_r6", 32'(rd_data_b0), 32'h7777);
        wait_done0("bypass_done");

        // clr_req held: busy returns one cycle after the done pulse
        clr_req0 = 1;
        cyc();
        wait_done0("held_done");
        chk("held_idle_at_done", 32'(clr_busy0), 32'd0);
        cyc();
        chk("held_restart", 32'(clr_busy0), 32'd1);
        clr_req0 = 0;
        wait_done0("held_done2");
        cyc();

        // reset in the middle of a clear
        wr_en0 = 1; wr_addr0 = 5; wr_data0 = 16'h5555;
        cyc();
        wr_en0 = 0; clr_req0 = 1;
        cyc();
        clr_req0 = 0;
        cyc(); cyc(); cyc();
        reset0 = 1;
        cyc();
        reset0 = 0;
        chk("midrst_busy", 32'(clr_busy0), 32'd0);
        chk("midrst_ready", 32'(wr_ready0), 32'd1);
        chk("midrst_done", 32'(clr_done0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a0 = 3'(i); rd_addr_b0 = 3'(7 - i);
            cyc();
            chk("midrst_no_done", 32'(clr_done0), 32'd0);
            chk("midrst_val", 32'(rd_data_a0), 32'hA5A5);
        end

        // 32-bit x 16 instance
        wr_en1 = 1; wr_addr1 = 9; wr_data1 = 32'h12345678; rd_addr_a1 = 9;
        cyc();
        wr_en1 = 0;
        chk("d1_bypass", rd_data_a1, 32'h12345678);
        clr_req1 = 1;
        cyc();
        clr_req1 = 0;
        n = 0;
        while (clr_busy1 && n < 40) begin
            n++;
            cyc();
        end
        chk("d1_busy_len", 32'(n), 32'd16);
        chk("d1_done", 32'(clr_done1), 32'd1);
        cyc();
        chk("d1_cleared", rd_data_a1, 32'd0);
        wr_en1 = 1; wr_addr1 = 9; wr_data1 = 32'hCAFEF00D;
        cyc();
        wr_en1 = 0; clr_req1 = 1;
        cyc();
        clr_req1 = 0;
        cyc(); cyc(); cyc();
        reset1 = 1;
        cyc();
        reset1 = 0;
        chk("d1_midrst_busy", 32'(clr_busy1), 32'd0);
        chk("d1_midrst_ready", 32'(wr_ready1), 32'd1);
        chk("d1_midrst_done", 32'(clr_done1), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a1 = 4'(i); rd_addr_b1 = 4'(15 - i);
            cyc();
            chk("d1_no_done", 32'(clr_done1), 32'd0);
            chk("d1_rst_a", rd_data_a1, 32'hDEADBEEF);
            chk("d1_rst_b", rd_data_b1, 32'hDEADBEEF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
